// File: rtl/tomasulo_rsv_station.sv
// tomasulo_rsv_station: N-entry reservation station with cdb_r wake-up and age-ordered issue.
// Define TOMASULO_RSV_STATION_CDB_BYPASS_EN to forward cdb_r into same-cycle eligibility and issue data.
package tomasulo_rsv_station_pkg;
  typedef enum logic [3:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MOV0, OP_MOV1, OP_MOVI} opcode_t;
  typedef logic [15:0] imm_t;
  typedef logic [3:0] tag_t;
  typedef logic [3:0] robid_t;
  typedef logic [4:0] reg_t;
  typedef logic [31:0] word_t;
  typedef struct packed {
    logic vld;
    tag_t tag;
    word_t wdata;
    robid_t robid;
    reg_t wa;
  } cdb_t;
  typedef struct packed {
    opcode_t op;
    word_t [1:0] rdata;
    imm_t imm;
    tag_t tag;
    robid_t robid;
    reg_t wa;
  } issue_t;
endpackage

module tomasulo_rsv_station
  import tomasulo_rsv_station_pkg::*;
#(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic disp_vld,
  output logic disp_rdy,
  input  opcode_t disp_op,
  input  imm_t disp_imm,
  input  tag_t disp_tag,
  input  robid_t disp_robid,
  input  reg_t disp_wa,
  input  logic [1:0] disp_src_rdy,
  input  tag_t [1:0] disp_src_tag,
  input  word_t [1:0] disp_src_data,
  input  cdb_t cdb_r,
  output logic iss_vld,
  output issue_t iss,
  output logic [$clog2(N+1)-1:0] occupancy
);
  localparam int CW = $clog2(N+1);
  localparam int IW = $clog2(N);
  typedef struct packed {
    opcode_t op;
    imm_t imm;
    tag_t tag;
    robid_t robid;
    reg_t wa;
    logic [1:0] rdy;
    tag_t [1:0] stag;
    word_t [1:0] data;
  } ent_t;
  logic [N-1:0] vld_q, vld_d, elig;
  ent_t ent_q [N];
  ent_t ent_d [N];
  // age_q[i][j] set means entry j is older than entry i
  logic [N-1:0] age_q [N];
  logic [N-1:0] age_d [N];
  logic [CW-1:0] occ_q, occ_d;
  logic [1:0] srdy [N];
  word_t [1:0] sdat [N];
  logic [IW-1:0] win, free;
  logic acc;

  function automatic logic hit(input cdb_t c, input tag_t t);
    return c.vld && c.tag == t;
  endfunction

  assign disp_rdy = occ_q < CW'(N);
  assign occupancy = occ_q;
  assign acc = disp_vld & disp_rdy & ~flush;

  always_comb begin
    win = '0;
    free = '0;
    elig = '0;
    iss = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 2; k++) begin
`ifdef TOMASULO_RSV_STATION_CDB_BYPASS_EN
        srdy[i][k] = ent_q[i].rdy[k] | hit(cdb_r, ent_q[i].stag[k]);
        sdat[i][k] = ent_q[i].rdy[k] ? ent_q[i].data[k] : cdb_r.wdata;
`else
        srdy[i][k] = ent_q[i].rdy[k];
        sdat[i][k] = ent_q[i].data[k];
`endif
      end
      elig[i] = vld_q[i] & (&srdy[i]);
    end
    for (int i = 0; i < N; i++) if (elig[i] && !(|(age_q[i] & elig))) win = IW'(i);
    for (int i = N-1; i >= 0; i--) if (!vld_q[i]) free = IW'(i);
    iss_vld = |elig;
    if (iss_vld) begin
      iss.op = ent_q[win].op;
      iss.rdata = sdat[win];
      iss.imm = ent_q[win].imm;
      iss.tag = ent_q[win].tag;
      iss.robid = ent_q[win].robid;
      iss.wa = ent_q[win].wa;
    end
  end

  always_comb begin
    ent_d = ent_q;
    age_d = age_q;
    vld_d = vld_q;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++)
        if (vld_q[i] && !ent_q[i].rdy[k] && hit(cdb_r, ent_q[i].stag[k])) begin
          ent_d[i].rdy[k] = 1'b1;
          ent_d[i].data[k] = cdb_r.wdata;
        end
    if (iss_vld) vld_d[win] = 1'b0;
    if (acc) begin
      vld_d[free] = 1'b1;
      ent_d[free].op = disp_op;
      ent_d[free].imm = disp_imm;
      ent_d[free].tag = disp_tag;
      ent_d[free].robid = disp_robid;
      ent_d[free].wa = disp_wa;
      ent_d[free].stag = disp_src_tag;
      for (int k = 0; k < 2; k++) begin
        ent_d[free].rdy[k] = disp_src_rdy[k] | hit(cdb_r, disp_src_tag[k]);
        ent_d[free].data[k] = disp_src_rdy[k] ? disp_src_data[k] : cdb_r.wdata;
      end
      // clearing the column drops stale "older" bits left by the previous occupant
      for (int j = 0; j < N; j++) age_d[j][free] = 1'b0;
      age_d[free] = vld_q;
    end
    if (flush) vld_d = '0;
    occ_d = flush ? '0 : occ_q + CW'(acc) - CW'(iss_vld);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      occ_q <= '0;
      for (int i = 0; i < N; i++) begin
        ent_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      occ_q <= occ_d;
      ent_q <= ent_d;
      age_q <= age_d;
    end
  end
endmodule

// File: tb/tb_tomasulo_rsv_station.sv
// tb_tomasulo_rsv_station: directed checks of dispatch, wake-up, age order, full, flush and reset.
module tb_tomasulo_rsv_station;
  import tomasulo_rsv_station_pkg::*;
`ifdef TOMASULO_RSV_STATION_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, flush, disp_vld, disp_rdy, iss_vld;
  opcode_t disp_op;
  imm_t disp_imm;
  tag_t disp_tag;
  robid_t disp_robid;
  reg_t disp_wa;
  logic [1:0] disp_src_rdy;
  tag_t [1:0] disp_src_tag;
  word_t [1:0] disp_src_data;
  cdb_t cdb_r;
  issue_t iss;
  logic [2:0] occupancy;
  int checks = 0;
  int errors = 0;

  tomasulo_rsv_station #(.N(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .disp_vld(disp_vld), .disp_rdy(disp_rdy),
    .disp_op(disp_op), .disp_imm(disp_imm), .disp_tag(disp_tag), .disp_robid(disp_robid),
    .disp_wa(disp_wa), .disp_src_rdy(disp_src_rdy), .disp_src_tag(disp_src_tag),
    .disp_src_data(disp_src_data), .cdb_r(cdb_r), .iss_vld(iss_vld), .iss(iss),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    disp_vld = 1'b0;
    flush = 1'b0;
    cdb_r = '0;
  endtask

  task automatic disp(input opcode_t op, input tag_t t, input logic [1:0] sr, input tag_t t1,
                      input tag_t t0, input word_t d1, input word_t d0);
    disp_vld = 1'b1;
    disp_op = op;
    disp_tag = t;
    disp_imm = {12'h0, t};
    disp_robid = t;
    disp_wa = {1'b0, t};
    disp_src_rdy = sr;
    disp_src_tag = {t1, t0};
    disp_src_data = {d1, d0};
  endtask

  task automatic bcast(input tag_t t, input word_t d);
    cdb_r = '0;
    cdb_r.vld = 1'b1;
    cdb_r.tag = t;
    cdb_r.wdata = d;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle();
    disp(OP_ADD, 0, 2'b00, 0, 0, 0, 0);
    disp_vld = 1'b0;
    #2;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    checks++; if (disp_rdy !== 1'b1) begin errors++; $display("FAIL reset_disp_rdy got %0b exp 1", disp_rdy); end
    checks++; if (iss_vld !== 1'b0) begin errors++; $display("FAIL reset_iss_vld got %0b exp 0", iss_vld); end
    checks++; if (iss !== '0) begin errors++; $display("FAIL reset_iss got %0h exp 0", iss); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic;
    disp(OP_AND, 7, 2'b11, 0, 0, 32'h3C, 32'h0F);
    #1;
    checks++; if (iss_vld !== 1'b0) begin errors++; $display("FAIL basic_pre_vld got %0b exp 0", iss_vld); end
    tick();
    idle();
    #1;
    checks++; if (iss_vld !== 1'b1) begin errors++; $display("FAIL basic_vld got %0b exp 1", iss_vld); end
    checks++; if (iss.rdata !== {32'h3C, 32'h0F}) begin errors++; $display("FAIL basic_rdata got %0h exp 3c_0f", iss.rdata); end
    checks++; if (iss.tag !== 4'd7) begin errors++; $display("FAIL basic_tag got %0d exp 7", iss.tag); end
    checks++; if (iss.op !== OP_AND) begin errors++; $display("FAIL basic_op got %0d exp %0d", iss.op, OP_AND); end
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL basic_occ1 got %0d exp 1", occupancy); end
    tick();
    #1;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL basic_occ0 got %0d exp 0", occupancy); end
    checks++; if (iss_vld !== 1'b0) begin errors++; $display("FAIL basic_post_vld got %0b exp 0", iss_vld); end
  endtask

  task automatic test_wakeup;
    disp(OP_OR, 8, 2'b10, 0, 5, 32'h11, 0);
    tick();
    idle();
    bcast(5, 32'hA5);
    #1;
    checks++; if (iss_vld !== BYP) begin errors++; $display("FAIL wake_cdb_vld got %0b exp %0b", iss_vld, BYP); end
    checks++; if (iss.rdata !== (BYP ? {32'h11, 32'hA5} : 64'h0)) begin errors++; $display("FAIL wake_cdb_rdata got %0h", iss.rdata); end
    tick();
    idle();
    #1;
    checks++; if (iss_vld !== !BYP) begin errors++; $display("FAIL wake_next_vld got %0b exp %0b", iss_vld, !BYP); end
    checks++; if (iss.rdata !== (BYP ? 64'h0 : {32'h11, 32'hA5})) begin errors++; $display("FAIL wake_next_rdata got %0h", iss.rdata); end
    tick();
    #1;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL wake_occ got %0d exp 0", occupancy); end
  endtask

  task automatic test_disp_capture;
    disp(OP_XOR, 9, 2'b01, 3, 0, 0, 32'h22);
    bcast(3, 32'h77);
    tick();
    idle();
    #1;
    checks++; if (iss_vld !== 1'b1) begin errors++; $display("FAIL cap_vld got %0b exp 1", iss_vld); end
    checks++; if (iss.rdata !== {32'h77, 32'h22}) begin errors++; $display("FAIL cap_rdata got %0h exp 77_22", iss.rdata); end
    checks++; if (iss.tag !== 4'd9) begin errors++; $display("FAIL cap_tag got %0d exp 9", iss.tag); end
    tick();
    #1;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL cap_occ got %0d exp 0", occupancy); end
  endtask

  task automatic test_full;
    for (int i = 0; i < 4; i++) begin
      disp(OP_ADD, tag_t'(10 + i), 2'b10, 0, tag_t'(1 + i), 32'hB0 + i, 0);
      tick();
    end
    disp(OP_ADD, 14, 2'b11, 0, 0, 32'hE1, 32'hE0);
    #1;
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_occ got %0d exp 4", occupancy); end
    checks++; if (disp_rdy !== 1'b0) begin errors++; $display("FAIL full_disp_rdy got %0b exp 0", disp_rdy); end
    checks++; if (iss_vld !== 1'b0) begin errors++; $display("FAIL full_iss got %0b exp 0", iss_vld); end
    tick();
    bcast(3, 32'h33);
    #1;
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_ignored got %0d exp 4", occupancy); end
    checks++; if (iss.tag !== (BYP ? 4'd12 : 4'd0)) begin errors++; $display("FAIL full_cdb_tag got %0d", iss.tag); end
    checks++; if (iss.rdata !== (BYP ? {32'hB2, 32'h33} : 64'h0)) begin errors++; $display("FAIL full_cdb_rdata got %0h", iss.rdata); end
    tick();
    cdb_r = '0;
    #1;
    checks++; if (iss_vld !== !BYP) begin errors++; $display("FAIL full_c7_vld got %0b exp %0b", iss_vld, !BYP); end
    checks++; if (iss.tag !== (BYP ? 4'd0 : 4'd12)) begin errors++; $display("FAIL full_c7_tag got %0d", iss.tag); end
    checks++; if (disp_rdy !== BYP) begin errors++; $display("FAIL full_c7_disp_rdy got %0b exp %0b", disp_rdy, BYP); end
    tick();
    #1;
    checks++; if (occupancy !== (BYP ? 3'd4 : 3'd3)) begin errors++; $display("FAIL full_c8_occ got %0d", occupancy); end
    checks++; if (iss_vld !== BYP) begin errors++; $display("FAIL full_c8_vld got %0b exp %0b", iss_vld, BYP); end
    checks++; if (iss.rdata !== (BYP ? {32'hE1, 32'hE0} : 64'h0)) begin errors++; $display("FAIL full_c8_rdata got %0h", iss.rdata); end
    tick();
    idle();
    #1;
    checks++; if (occupancy !== (BYP ? 3'd3 : 3'd4)) begin errors++; $display("FAIL full_c9_occ got %0d", occupancy); end
    checks++; if (iss.tag !== (BYP ? 4'd0 : 4'd14)) begin errors++; $display("FAIL full_c9_tag got %0d", iss.tag); end
    tick();
    #1;
    checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL full_c10_occ got %0d exp 3", occupancy); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL full_flush_occ got %0d exp 0", occupancy); end
  endtask

  task automatic test_age;
    disp(OP_SUB, 6, 2'b10, 0, 2, 32'hA1, 0);
    tick();
    disp(OP_ADD, 7, 2'b11, 0, 0, 32'hB1, 32'hB0);
    #1;
    checks++; if (iss_vld !== 1'b0) begin errors++; $display("FAIL age_a2_vld got %0b exp 0", iss_vld); end
    tick();
    idle();
    #1;
    checks++; if (iss.tag !== 4'd7 || iss_vld !== 1'b1) begin errors++; $display("FAIL age_b_first got %0d exp 7", iss.tag); end
    tick();
    bcast(2, 32'h55);
    #1;
    checks++; if (iss.tag !== (BYP ? 4'd6 : 4'd0)) begin errors++; $display("FAIL age_a_cdb got %0d", iss.tag); end
    tick();
    idle();
    #1;
    checks++; if (iss.rdata !== (BYP ? 64'h0 : {32'hA1, 32'h55})) begin errors++; $display("FAIL age_a_next got %0h", iss.rdata); end
    tick();
    disp(OP_AND, 11, 2'b10, 0, 12, 32'hC1, 0);
    tick();
    disp(OP_AND, 13, 2'b10, 0, 9, 32'hD1, 0);
    tick();
    disp(OP_AND, 14, 2'b10, 0, 9, 32'hD2, 0);
    tick();
    idle();
    bcast(12, 32'h66);
    #1;
    checks++; if (iss.tag !== (BYP ? 4'd11 : 4'd0)) begin errors++; $display("FAIL age_x_cdb got %0d", iss.tag); end
    tick();
    idle();
    #1;
    checks++; if (iss.tag !== (BYP ? 4'd0 : 4'd11)) begin errors++; $display("FAIL age_x_next got %0d", iss.tag); end
    tick();
    disp(OP_AND, 15, 2'b10, 0, 9, 32'hD3, 0);
    #1;
    checks++; if (iss_vld !== 1'b0) begin errors++; $display("FAIL age_w_disp got %0b exp 0", iss_vld); end
    tick();
    idle();
    for (int j = 0; j < 4; j++) begin
      tag_t exp;
      exp = BYP ? (j < 3 ? tag_t'(13 + j) : 4'd0) : (j > 0 ? tag_t'(12 + j) : 4'd0);
      if (j == 0) bcast(9, 32'h99);
      else cdb_r = '0;
      #1;
      checks++; if (iss.tag !== exp || iss_vld !== (exp != 0)) begin errors++; $display("FAIL age_order_%0d got %0d/%0b exp %0d", j, iss.tag, iss_vld, exp); end
      tick();
    end
    #1;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL age_occ got %0d exp 0", occupancy); end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) begin
      disp(OP_OR, tag_t'(4 + i), 2'b01, tag_t'(1 + i), 0, 0, 32'h10 + i);
      tick();
    end
    disp(OP_ADD, 7, 2'b11, 0, 0, 32'h1, 32'h2);
    flush = 1'b1;
    #1;
    checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL flush_pre_occ got %0d exp 3", occupancy); end
    tick();
    idle();
    #1;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL flush_occ got %0d exp 0", occupancy); end
    checks++; if (iss_vld !== 1'b0) begin errors++; $display("FAIL flush_dropped got %0b exp 0", iss_vld); end
    for (int t = 1; t <= 3; t++) begin
      tick();
      bcast(tag_t'(t), 32'h40 + t);
      #1;
      checks++; if (iss_vld !== 1'b0) begin errors++; $display("FAIL flush_cdb_%0d got %0b exp 0", t, iss_vld); end
    end
    tick();
    idle();
    #1;
    checks++; if (iss_vld !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL flush_after got %0b/%0d exp 0/0", iss_vld, occupancy); end
  endtask

  task automatic test_reset_mid;
    disp(OP_MOVI, 2, 2'b10, 0, 8, 32'h5, 0);
    tick();
    idle();
    #1;
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL rmid_pre_occ got %0d exp 1", occupancy); end
    rst = 1'b1;
    #1;
    checks++; if (occupancy !== 3'd0 || disp_rdy !== 1'b1) begin errors++; $display("FAIL rmid_async got %0d/%0b exp 0/1", occupancy, disp_rdy); end
    rst = 1'b0;
    tick();
    bcast(8, 32'h88);
    #1;
    checks++; if (iss_vld !== 1'b0) begin errors++; $display("FAIL rmid_cdb got %0b exp 0", iss_vld); end
    tick();
    idle();
    #1;
    checks++; if (iss_vld !== 1'b0) begin errors++; $display("FAIL rmid_next got %0b exp 0", iss_vld); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_disp_capture();
    test_full();
    test_age();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tomasulo_rsv_station.md
# tomasulo_rsv_station

Reservation station that sits between dispatch and `tomasulo_exe_logic`. It accepts dispatched instructions whose source operands may still be pending and snoops the registered common data bus (`cdb_r`) broadcast by the execution unit to capture pending operands. Each cycle it issues the oldest fully-ready entry as an `issue_t` to the execution unit. It is the consumer (wake-up) end of the CDB protocol whose producer is the execution unit.

## Interface
Parameters:
- `N`, 4, number of entries (2..16).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous; invalidates all entries.
- `disp_vld`  in  1  dispatch request.
- `disp_rdy`  out  1  station can accept a dispatch this cycle.
- `disp_op`  in  opcode_t  operation.
- `disp_imm`  in  imm_t  immediate.
- `disp_tag`  in  tag_t  result tag broadcast on completion.
- `disp_robid`  in  robid_t  ROB index.
- `disp_wa`  in  reg_t  architectural destination.
- `disp_src_rdy`  in  2  per-source operand-present flag.
- `disp_src_tag`  in  2 x tag_t  producer tag for each source not present.
- `disp_src_data`  in  2 x word_t  operand value for each source present.
- `cdb_r`  in  cdb_t  registered CDB (`vld`, `tag`, `wdata`, `robid`, `wa`).
- `iss_vld`  out  1  issue valid.
- `iss`  out  issue_t  issued instruction (`op`, `rdata[1:0]`, `imm`, `tag`, `robid`, `wa`).
- `occupancy`  out  $clog2(N+1)  number of valid entries.

## Operation
- Each entry holds: `vld`, `op`, `imm`, `tag`, `robid`, `wa`, and per source `rdy`, `src_tag`, `data`.
- Dispatch: when `disp_vld & disp_rdy`, the lowest-index free entry is written. If `disp_vld` is asserted while `disp_rdy` is low, the request is ignored; the upstream holds it.
- Wake-up: for every valid entry and every source with `rdy==0`, a match on `cdb_r.vld && cdb_r.tag==src_tag` sets `rdy` and captures `cdb_r.wdata`.
  - The same match is applied to the dispatch operands in the cycle they are written. An operand whose producer broadcasts in the dispatch cycle is therefore captured, not lost.
- Selection: an entry is eligible when `vld` is set and both sources are `rdy`.
  - The oldest eligible entry wins. Age is tracked by an N x N age matrix set on dispatch.
  - `iss_vld` is asserted with the winner's fields. `iss.rdata[k]` is the captured source data.
  - The winner is freed at the clock edge. The execution unit never back-pressures.
- Sources that are unused for an opcode (`OP_NOT`, `OP_MOV0`, `OP_MOV1`, `OP_MOVI`) are dispatched with `disp_src_rdy` set. The station does not decode opcodes.
- Flush: all `vld` bits are cleared at the next edge. An issue in the flush cycle still occurs. A dispatch in the flush cycle is dropped.

## Timing
- Reset values: all entries invalid, age matrix zero, `disp_rdy=1`, `iss_vld=0`, `iss='0`, `occupancy=0`.
- `disp_rdy = (occupancy < N)`. It is computed from flops only and does not credit a same-cycle issue. A full station accepts the next dispatch one cycle after an issue.
- Dispatch-to-issue latency with all operands ready: 1 cycle. The entry is written at edge T and issues in cycle T+1.
- Wake-up-to-issue latency (without the macro): the CDB is visible in cycle T, data is captured at edge T, and the entry is eligible in cycle T+1.
- `iss` is combinational from entry flops, plus `cdb_r` with the macro enabled. When `iss_vld=0`, `iss` is driven to `'0`.
- Simultaneous dispatch and issue with a full station: the issue occurs and the dispatch is not accepted.
- `occupancy` update: +1 per accepted dispatch, −1 per issue; both in the same cycle give a net 0.
- Reset asserted mid-operation clears all state immediately. Pending operands are discarded.

## Configuration
- `TOMASULO_RSV_STATION_CDB_BYPASS_EN` defined: an entry whose last pending source matches `cdb_r` in cycle T is eligible in cycle T. Its `iss.rdata` for that source is forwarded from `cdb_r.wdata`, saving one cycle per dependent chain.
  - This bypass does not apply to entries being dispatched in cycle T.
- Not defined: wake-up is registered-only, and eligibility is computed purely from entry flops, as in Timing.

## Test plan
- Reset, then dispatch `OP_AND` with sources 0x0F and 0x3C both ready -> `iss_vld=1` one cycle later with `rdata={0x3C,0x0F}` and the dispatched tag; `occupancy` returns to 0.
- Dispatch `OP_OR` with source 0 waiting on tag 5, then drive `cdb_r={vld:1,tag:5,wdata:0xA5}` -> issue with `rdata[0]=0xA5`.
  - One cycle after the CDB without the macro; the same cycle with the macro.
- Dispatch with source 1 waiting on tag 3 in the same cycle that `cdb_r` broadcasts tag 3 / 0x77 -> the operand is captured and the entry issues next cycle with `rdata[1]=0x77`.
- N=4: fill 4 entries waiting on tags 1..4, then `disp_rdy=0` and a fifth `disp_vld` is ignored. Broadcast tag 3 -> entry 3 issues, and `disp_rdy` rises the cycle after.
- Dispatch A (waiting on tag 2) then B (ready). B issues first. Broadcast tag 2 -> A issues. Two entries made ready on the same cycle -> the older issues first.
- Assert `flush` with 3 entries valid plus a concurrent dispatch -> `occupancy=0` next cycle, and no further `iss_vld` even when their tags are later broadcast.
